load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake and byte-addressed memory port of the load/store unit.
// Port names match the pipeline and memory they connect to.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output stall, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_ctrl, mem_wr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_ctrl, mem_wr
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits misaligned accesses into byte beats, drives a registered memory
// port, and returns sign/zero-extended load data with a one-cycle completion pulse.
module load_store_unit (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, SAMPLE, DONE} state_t;

  state_t      r_state, w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_buf;
  logic [1:0]  r_beat, w_beat_nxt;
  logic        r_mem_wr;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [2:0]  r_mem_ctrl;

  logic        w_we;
  logic [2:0]  w_funct3;
  logic [31:0] w_addr, w_wdata;
  logic        w_illegal, w_misal, w_mem_go, w_accept;
  logic [1:0]  w_last;
  logic [7:0]  w_byte;

  function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'b0, d[7:0]};
      3'b101:  return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Decode works on the live inputs while idle (accept cycle) and on the latched copy afterwards
  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_we     = (r_state == IDLE) ? bus.req_we     : r_we;
  assign w_funct3 = (r_state == IDLE) ? bus.req_funct3 : r_funct3;
  assign w_addr   = (r_state == IDLE) ? bus.req_addr   : r_addr;
  assign w_wdata  = (r_state == IDLE) ? bus.req_wdata  : r_wdata;

  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    case (w_funct3[1:0])
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = w_addr[0];
      2'b10:   w_misal = |w_addr[1:0];
      default: w_illegal = 1'b1;
    endcase
    if (w_we && w_funct3[2]) w_illegal = 1'b1;
    w_last = 2'd0;
    if (w_misal) w_last = w_funct3[1] ? 2'd3 : 2'd1;
  end

  always_comb begin
    w_next     = r_state;
    w_beat_nxt = r_beat;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_beat_nxt = 2'd0;
          if (w_illegal)  w_next = DONE;
          else if (w_we)  w_next = SETUP;
          else            w_next = SAMPLE;
        end
      end
      SETUP:  w_next = STROBE;
      STROBE: begin
        if (r_beat == w_last) begin
          w_next = DONE;
        end else begin
          w_next     = SETUP;
          w_beat_nxt = r_beat + 2'd1;
        end
      end
      SAMPLE: begin
        if (r_beat == w_last) begin
          w_next = DONE;
        end else begin
          w_beat_nxt = r_beat + 2'd1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_byte = w_wdata[7:0];
    case (w_beat_nxt)
      2'd0: w_byte = w_wdata[7:0];
      2'd1: w_byte = w_wdata[15:8];
      2'd2: w_byte = w_wdata[23:16];
      2'd3: w_byte = w_wdata[31:24];
      default: w_byte = w_wdata[7:0];
    endcase
  end

  assign w_mem_go = (w_next == SETUP) || (w_next == STROBE) || (w_next == SAMPLE);

  // Memory port is registered from next-state values so it is stable for the whole beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= 2'd0;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_buf       <= 32'h0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_ctrl  <= 3'b000;
    end else begin
      r_state  <= w_next;
      r_beat   <= w_beat_nxt;
      r_mem_wr <= (w_next == STROBE);
      if (w_mem_go) begin
        r_mem_addr  <= w_addr + {30'b0, w_beat_nxt};
        r_mem_ctrl  <= w_misal ? 3'b000 : {1'b0, w_funct3[1:0]};
        r_mem_wdata <= w_misal ? {24'b0, w_byte} : w_wdata;
      end
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_buf    <= 32'h0;
      end
      if (r_state == SAMPLE) begin
        if (w_misal) r_buf[{r_beat, 3'b000} +: 8] <= bus.mem_rdata[7:0];
        else         r_buf <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_ctrl  = r_mem_ctrl;

  assign bus.stall     = w_accept || (r_state == SETUP) || (r_state == STROBE) || (r_state == SAMPLE);
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_err   = (r_state == DONE) && w_illegal;
  assign bus.rsp_rdata = ((r_state == DONE) && !w_illegal && !w_we) ? f_extend(w_funct3, r_buf) : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory model, vector table of accesses,
// and hand-written sequences for beat ordering and mid-access reset.
module tb_load_store_unit;
  logic clk;
  logic rst_n;
  load_store_unit_if bus();

  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
  } pulse_t;

  logic [7:0]  mem [256];
  pulse_t      pulses [$];
  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] rd;

  assign a0 = bus.mem_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;

  always_comb begin
    rd = 32'h0;
    case (bus.mem_ctrl)
      3'b000:  rd = {24'h0, mem[a0]};
      3'b001:  rd = {16'h0, mem[a1], mem[a0]};
      3'b010:  rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
      default: rd = 32'h0;
    endcase
  end
  assign bus.mem_rdata = rd;

  always @(posedge bus.mem_wr) begin
    case (bus.mem_ctrl)
      3'b000: mem[a0] <= bus.mem_wdata[7:0];
      3'b001: begin
        mem[a0] <= bus.mem_wdata[7:0];
        mem[a1] <= bus.mem_wdata[15:8];
      end
      3'b010: begin
        mem[a0] <= bus.mem_wdata[7:0];
        mem[a1] <= bus.mem_wdata[15:8];
        mem[a2] <= bus.mem_wdata[23:16];
        mem[a3] <= bus.mem_wdata[31:24];
      end
      default: ;
    endcase
    pulses.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_ctrl});
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          np;
  } vec_t;

  localparam int NV = 20;
  vec_t        vt [NV];
  int          n_chk, n_fail;
  logic [31:0] samp_a [$];
  logic [2:0]  samp_c [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err, output int np);
    int p0;
    p0 = pulses.size();
    samp_a.delete();
    samp_c.delete();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1 chk("stall_on_request", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = ~addr;
    bus.req_wdata  = ~wdata;
    lat   = -1;
    rdata = 32'hxxxxxxxx;
    err   = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat   = k;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        chk("stall_in_done", {31'b0, bus.stall}, 32'd0);
        break;
      end
      chk("stall_busy", {31'b0, bus.stall}, 32'd1);
      samp_a.push_back(bus.mem_addr);
      samp_c.push_back(bus.mem_ctrl);
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within 20 cycles, expected one");
    end else begin
      @(negedge clk);
      chk("rsp_single_cycle", {31'b0, bus.rsp_valid}, 32'd0);
    end
    np = pulses.size() - p0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, np, p0;
    logic [31:0] rdv;
    logic        erv;

    n_chk = 0;
    n_fail = 0;
    //        we    f3      addr          wdata          lat rdata          err  np
    vt[0]  = '{1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 3, 32'h00000000, 1'b0, 1};
    vt[1]  = '{1'b1, 3'b010, 32'h00000003, 32'h11223344, 9, 32'h00000000, 1'b0, 4};
    vt[2]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        2, 32'hDEADBEEF, 1'b0, 0};
    vt[3]  = '{1'b0, 3'b010, 32'h00000003, 32'h0,        5, 32'h11223344, 1'b0, 0};
    vt[4]  = '{1'b1, 3'b000, 32'h00000021, 32'hAAAAAA80, 3, 32'h00000000, 1'b0, 1};
    vt[5]  = '{1'b1, 3'b000, 32'h00000022, 32'h000000FF, 3, 32'h00000000, 1'b0, 1};
    vt[6]  = '{1'b1, 3'b000, 32'h00000005, 32'h5555559C, 3, 32'h00000000, 1'b0, 1};
    vt[7]  = '{1'b1, 3'b001, 32'hFFFFFFFF, 32'h00001234, 5, 32'h00000000, 1'b0, 2};
    vt[8]  = '{1'b0, 3'b001, 32'h00000021, 32'h0,        3, 32'hFFFFFF80, 1'b0, 0};
    vt[9]  = '{1'b0, 3'b101, 32'h00000021, 32'h0,        3, 32'h0000FF80, 1'b0, 0};
    vt[10] = '{1'b0, 3'b000, 32'h00000005, 32'h0,        2, 32'hFFFFFF9C, 1'b0, 0};
    vt[11] = '{1'b0, 3'b100, 32'h00000005, 32'h0,        2, 32'h0000009C, 1'b0, 0};
    vt[12] = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,        3, 32'h00001234, 1'b0, 0};
    vt[13] = '{1'b0, 3'b001, 32'h00000004, 32'h0,        2, 32'hFFFF9C33, 1'b0, 0};
    vt[14] = '{1'b0, 3'b101, 32'h00000004, 32'h0,        2, 32'h00009C33, 1'b0, 0};
    vt[15] = '{1'b0, 3'b011, 32'h00000010, 32'h0,        1, 32'h00000000, 1'b1, 0};
    vt[16] = '{1'b1, 3'b101, 32'h00000010, 32'h12345678, 1, 32'h00000000, 1'b1, 0};
    vt[17] = '{1'b0, 3'b111, 32'h00000010, 32'h0,        1, 32'h00000000, 1'b1, 0};
    vt[18] = '{1'b1, 3'b001, 32'h00000008, 32'h7777BEEF, 3, 32'h00000000, 1'b0, 1};
    vt[19] = '{1'b0, 3'b101, 32'h00000008, 32'h0,        2, 32'h0000BEEF, 1'b0, 0};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall",     {31'b0, bus.stall},     32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, bus.rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
    chk("rst_mem_wr",    {31'b0, bus.mem_wr},    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,           32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
    chk("rst_mem_ctrl",  {29'b0, bus.mem_ctrl},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, rdv, erv, np);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_rdata", i), rdv, vt[i].rdata);
      chk($sformatf("v%0d_err", i), {31'b0, erv}, {31'b0, vt[i].err});
      chk($sformatf("v%0d_wr_pulses", i), np, vt[i].np);
    end

    // Aligned SW: single word beat
    p0 = pulses.size();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rdv, erv, np);
    chk("sw_al_pulses", np, 32'd1);
    if (np == 1) begin
      chk("sw_al_addr",  pulses[p0].a, 32'h10);
      chk("sw_al_wdata", pulses[p0].d, 32'hDEADBEEF);
      chk("sw_al_ctrl",  {29'b0, pulses[p0].c}, 32'd2);
    end

    // Misaligned SW: four byte beats in ascending address order
    p0 = pulses.size();
    do_req(1'b1, 3'b010, 32'h03, 32'h11223344, lat, rdv, erv, np);
    chk("sw_mis_latency", lat, 32'd9);
    chk("sw_mis_pulses", np, 32'd4);
    if (np == 4) begin
      for (int b = 0; b < 4; b++) begin
        logic [31:0] wexp;
        wexp = 32'h11223344 >> (8 * b);
        chk($sformatf("sw_mis_b%0d_addr", b), pulses[p0 + b].a, 32'h3 + b);
        chk($sformatf("sw_mis_b%0d_wdata", b), pulses[p0 + b].d, {24'b0, wexp[7:0]});
        chk($sformatf("sw_mis_b%0d_ctrl", b), {29'b0, pulses[p0 + b].c}, 32'd0);
      end
    end

    // Misaligned LH: byte reads at 0x21 then 0x22
    do_req(1'b0, 3'b001, 32'h21, 32'h0, lat, rdv, erv, np);
    chk("lh_mis_beats", samp_a.size(), 32'd2);
    if (samp_a.size() == 2) begin
      chk("lh_mis_addr0", samp_a[0], 32'h21);
      chk("lh_mis_addr1", samp_a[1], 32'h22);
      chk("lh_mis_ctrl0", {29'b0, samp_c[0]}, 32'd0);
      chk("lh_mis_ctrl1", {29'b0, samp_c[1]}, 32'd0);
    end

    // Misaligned LH across the top of the address space wraps to 0
    do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, lat, rdv, erv, np);
    chk("lh_wrap_beats", samp_a.size(), 32'd2);
    if (samp_a.size() == 2) begin
      chk("lh_wrap_addr0", samp_a[0], 32'hFFFFFFFF);
      chk("lh_wrap_addr1", samp_a[1], 32'h00000000);
    end

    // Aligned LW: one word beat
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rdv, erv, np);
    chk("lw_al_beats", samp_a.size(), 32'd1);
    if (samp_a.size() == 1) begin
      chk("lw_al_addr", samp_a[0], 32'h10);
      chk("lw_al_ctrl", {29'b0, samp_c[0]}, 32'd2);
    end

    // Reset during the strobe of beat 1 of a misaligned SW
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h3;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_pre_mem_wr",   {31'b0, bus.mem_wr}, 32'd1);
    chk("mid_pre_mem_addr", bus.mem_addr,        32'h4);
    p0 = pulses.size();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_wr",    {31'b0, bus.mem_wr},    32'd0);
    chk("mid_rst_stall",     {31'b0, bus.stall},     32'd0);
    chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_mem_addr",  bus.mem_addr,           32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_post_pulses",    pulses.size() - p0,  32'd0);
    chk("mid_post_stall",     {31'b0, bus.stall},  32'd0);
    chk("mid_post_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

    // Unit accepts again after reset; beat 0 of the abandoned store wrote 0x0D at 0x03
    do_req(1'b0, 3'b000, 32'h3, 32'h0, lat, rdv, erv, np);
    chk("post_rst_lb_latency", lat, 32'd2);
    chk("post_rst_lb_rdata",   rdv, 32'h0000000D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
